// File: rtl/regfile_banked_pkg.sv
// regfile_banked_pkg: bank encodings, reset defaults and special register indices
package regfile_banked_pkg;
  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FP = 1'b1;
  localparam int SP_INIT_DEF = 256;
  localparam int REG_X0 = 0;
  localparam int REG_SP = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for both banks with issue/write/flush update.
// REGFILE_BYPASS_EN: rbusy also drops for registers retiring in the current cycle.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NREAD = 3,
  parameter int NWRITE = 2,
  parameter int IW = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NWRITE-1:0]   wv,
  input  logic [NWRITE*IW-1:0] widx,
  input  logic                iss_en,
  input  logic [IW-1:0]       iss_idx,
  input  logic                flush,
  input  logic [NREAD*IW-1:0] ridx,
  output logic [NREAD-1:0]    rbusy
);
  logic [2*NREGS-1:0] busy, hit_w, hit_i;
  assign hit_i = {{(2*NREGS-1){1'b0}}, iss_en} << iss_idx;
  always_comb begin
    hit_w = '0;
    for (int p = 0; p < NWRITE; p++)
      if (wv[p]) hit_w[widx[p*IW +: IW]] = 1'b1;
  end
  // a new issue supersedes a retiring write to the same register
  always_ff @(posedge clock or negedge reset)
    if (!reset) busy <= '0;
    else busy <= flush ? '0 : hit_i | (busy & ~hit_w);
  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NREAD; k++)
`ifdef REGFILE_BYPASS_EN
      rbusy[k] = busy[ridx[k*IW +: IW]] & ~(hit_w[ridx[k*IW +: IW]] & ~hit_i[ridx[k*IW +: IW]]);
`else
      rbusy[k] = busy[ridx[k*IW +: IW]];
`endif
  end
endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: two-bank (int/float) multi-port register file with busy scoreboard.
// REGFILE_BYPASS_EN: same-cycle write-to-read forwarding of data and busy.
module regfile_banked
  import regfile_banked_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 3,
  parameter int NWRITE = 2,
  parameter int SP_INIT = SP_INIT_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   ra,
  input  logic [NREAD-1:0]      rbank,
  output logic [NREAD*XLEN-1:0] rd,
  output logic [NREAD-1:0]      rbusy,
  input  logic [NWRITE-1:0]     wen,
  input  logic [NWRITE-1:0]     wbank,
  input  logic [NWRITE*AW-1:0]  wa,
  input  logic [NWRITE*XLEN-1:0] wd,
  input  logic                  iss_en,
  input  logic                  iss_bank,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush
);
  localparam int IW = AW + 1;
  logic [XLEN-1:0] mem [2*NREGS];
  logic [NWRITE-1:0] wv;
  logic [NWRITE*IW-1:0] widx;
  logic [NREAD*IW-1:0] ridx;
  logic iss_ok;
  // flat index {bank, addr}: integer bank occupies the lower half
  always_comb begin
    wv = '0;
    widx = '0;
    ridx = '0;
    for (int p = 0; p < NWRITE; p++) begin
      widx[p*IW +: IW] = {wbank[p], wa[p*AW +: AW]};
      wv[p] = wen[p] && !(wbank[p] == BANK_INT && wa[p*AW +: AW] == AW'(REG_X0));
    end
    for (int k = 0; k < NREAD; k++)
      ridx[k*IW +: IW] = {rbank[k], ra[k*AW +: AW]};
  end
  assign iss_ok = iss_en && !(iss_bank == BANK_INT && iss_addr == AW'(REG_X0));
  // later ports overwrite earlier ones, giving the highest index priority
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 2*NREGS; i++)
        mem[i] <= (i == REG_SP) ? XLEN'(SP_INIT) : '0;
    end else begin
      for (int p = 0; p < NWRITE; p++)
        if (wv[p]) mem[widx[p*IW +: IW]] <= wd[p*XLEN +: XLEN];
    end
  always_comb begin
    rd = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd[k*XLEN +: XLEN] = mem[ridx[k*IW +: IW]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWRITE; p++)
        if (wv[p] && widx[p*IW +: IW] == ridx[k*IW +: IW]) rd[k*XLEN +: XLEN] = wd[p*XLEN +: XLEN];
`endif
    end
  end
  regfile_scoreboard #(.NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .IW(IW)) u_sb (
    .clock(clock),
    .reset(reset),
    .wv(wv),
    .widx(widx),
    .iss_en(iss_ok),
    .iss_idx({iss_bank, iss_addr}),
    .flush(flush),
    .ridx(ridx),
    .rbusy(rbusy)
  );
endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: scoreboard-queue bench for regfile_banked; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_banked;
  localparam int XLEN = 32, NREGS = 32, NREAD = 3, NWRITE = 2, AW = 5;
  localparam logic INT = 1'b0, FP = 1'b1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock, reset, iss_en, iss_bank, flush;
  logic [NREAD*AW-1:0] ra;
  logic [NREAD-1:0] rbank, rbusy;
  logic [NREAD*XLEN-1:0] rd;
  logic [NWRITE-1:0] wen, wbank;
  logic [NWRITE*AW-1:0] wa;
  logic [NWRITE*XLEN-1:0] wd;
  logic [AW-1:0] iss_addr;
  logic [XLEN-1:0] exp_q[$];
  bit expb_q[$];
  logic [XLEN-1:0] e;
  bit eb;
  int checks = 0, errors = 0;

  regfile_banked #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .SP_INIT(256)) dut (
    .clock(clock), .reset(reset), .ra(ra), .rbank(rbank), .rd(rd), .rbusy(rbusy),
    .wen(wen), .wbank(wbank), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_bank(iss_bank),
    .iss_addr(iss_addr), .flush(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task idle;
    wen = '0;
    iss_en = 1'b0;
    flush = 1'b0;
  endtask

  task set_rd(input int k, input logic b, input int a);
    rbank[k] = b;
    ra[k*AW +: AW] = a[AW-1:0];
  endtask

  task set_wr(input int p, input logic b, input int a, input logic [XLEN-1:0] d);
    wen[p] = 1'b1;
    wbank[p] = b;
    wa[p*AW +: AW] = a[AW-1:0];
    wd[p*XLEN +: XLEN] = d;
  endtask

  task issue(input logic b, input int a);
    iss_en = 1'b1;
    iss_bank = b;
    iss_addr = a[AW-1:0];
  endtask

  task test_reset;
    reset = 1'b0;
    idle();
    ra = '0; rbank = '0; wbank = '0; wa = '0; wd = '0; iss_bank = 1'b0; iss_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    set_rd(0, INT, 2);
    set_rd(1, FP, 2);
    exp_q.push_back(32'd256);
    exp_q.push_back(32'd0);
    expb_q.push_back(1'b0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL reset_x2: rd=%h exp=%h", rd[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if (rd[XLEN +: XLEN] !== e) begin errors++; $display("FAIL reset_f2: rd=%h exp=%h", rd[XLEN +: XLEN], e); end
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL reset_x2_busy: rbusy=%b exp=%b", rbusy[0], eb); end
    for (int i = 0; i < 2*NREGS; i++) begin
      if (i != 2) begin
        set_rd(2, i >= NREGS, i % NREGS);
        exp_q.push_back(32'd0);
        #0.1;
        e = exp_q.pop_front(); checks++;
        if (rd[2*XLEN +: XLEN] !== e || rbusy[2] !== 1'b0) begin
          errors++; $display("FAIL reset_reg%0d: rd=%h busy=%b exp=%h busy 0", i, rd[2*XLEN +: XLEN], rbusy[2], e);
        end
      end
    end
  endtask

  task test_x0_f0;
    @(negedge clock);
    set_wr(0, INT, 0, 32'hDEAD);
    set_rd(0, INT, 0);
    exp_q.push_back(32'd0);
    @(negedge clock); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL x0_write_ignored: rd=%h exp=%h", rd[0 +: XLEN], e); end
    set_wr(0, FP, 0, 32'h3F800000);
    set_rd(0, FP, 0);
    exp_q.push_back(32'h3F800000);
    @(negedge clock); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL f0_write: rd=%h exp=%h", rd[0 +: XLEN], e); end
  endtask

  task test_write_conflict;
    @(negedge clock);
    set_wr(0, INT, 5, 32'h11);
    set_wr(1, INT, 5, 32'h22);
    set_rd(0, INT, 5);
    exp_q.push_back(BYP ? 32'h22 : 32'h0);
    exp_q.push_back(32'h22);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL conflict_same_cycle: rd=%h exp=%h", rd[0 +: XLEN], e); end
    @(negedge clock); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL conflict_stored: rd=%h exp=%h", rd[0 +: XLEN], e); end
  endtask

  task test_busy;
    @(negedge clock);
    issue(FP, 3);
    @(negedge clock); idle();
    set_rd(0, FP, 3);
    set_rd(1, INT, 3);
    expb_q.push_back(1'b1);
    expb_q.push_back(1'b0);
    #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL busy_f3: rbusy=%b exp=%b", rbusy[0], eb); end
    eb = expb_q.pop_front(); checks++;
    if (rbusy[1] !== eb) begin errors++; $display("FAIL busy_x3: rbusy=%b exp=%b", rbusy[1], eb); end
    @(negedge clock);
    set_wr(1, FP, 3, 32'h40000000);
    expb_q.push_back(BYP ? 1'b0 : 1'b1);
    exp_q.push_back(BYP ? 32'h40000000 : 32'h0);
    #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL busy_f3_wb_cycle: rbusy=%b exp=%b", rbusy[0], eb); end
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL f3_wb_cycle: rd=%h exp=%h", rd[0 +: XLEN], e); end
    expb_q.push_back(1'b0);
    exp_q.push_back(32'h40000000);
    @(negedge clock); idle(); #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL busy_f3_cleared: rbusy=%b exp=%b", rbusy[0], eb); end
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL f3_stored: rd=%h exp=%h", rd[0 +: XLEN], e); end
    @(negedge clock);
    issue(INT, 0);
    set_rd(0, INT, 0);
    expb_q.push_back(1'b0);
    @(negedge clock); idle(); #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL busy_x0_issue: rbusy=%b exp=%b", rbusy[0], eb); end
  endtask

  task test_issue_write;
    @(negedge clock);
    issue(INT, 7);
    set_wr(0, INT, 7, 32'h9);
    set_rd(0, INT, 7);
    expb_q.push_back(1'b0);
    #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL iw_x7_busy_same_cycle: rbusy=%b exp=%b", rbusy[0], eb); end
    exp_q.push_back(32'h9);
    expb_q.push_back(1'b1);
    @(negedge clock); idle(); #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL iw_x7_data: rd=%h exp=%h", rd[0 +: XLEN], e); end
    eb = expb_q.pop_front(); checks++;
    if (rbusy[0] !== eb) begin errors++; $display("FAIL iw_x7_busy: rbusy=%b exp=%b", rbusy[0], eb); end
  endtask

  task test_flush;
    @(negedge clock);
    issue(INT, 9);
    @(negedge clock); idle();
    set_rd(2, INT, 9);
    expb_q.push_back(1'b1);
    #1;
    eb = expb_q.pop_front(); checks++;
    if (rbusy[2] !== eb) begin errors++; $display("FAIL flush_pre_x9: rbusy=%b exp=%b", rbusy[2], eb); end
    flush = 1'b1;
    issue(INT, 8);
    set_rd(0, INT, 7);
    set_rd(1, INT, 8);
    expb_q.push_back(1'b0); expb_q.push_back(1'b0); expb_q.push_back(1'b0);
    exp_q.push_back(32'h9);
    @(negedge clock); idle(); #1;
    for (int k = 0; k < NREAD; k++) begin
      eb = expb_q.pop_front(); checks++;
      if (rbusy[k] !== eb) begin errors++; $display("FAIL flush_busy_port%0d: rbusy=%b exp=%b", k, rbusy[k], eb); end
    end
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL flush_keeps_x7: rd=%h exp=%h", rd[0 +: XLEN], e); end
  endtask

  task test_async_reset;
    @(negedge clock);
    set_wr(0, INT, 4, 32'h55);
    issue(INT, 10);
    @(negedge clock); idle();
    set_rd(0, INT, 4);
    set_rd(1, INT, 2);
    set_rd(2, INT, 10);
    exp_q.push_back(32'h55);
    expb_q.push_back(1'b1);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL ar_x4_before: rd=%h exp=%h", rd[0 +: XLEN], e); end
    eb = expb_q.pop_front(); checks++;
    if (rbusy[2] !== eb) begin errors++; $display("FAIL ar_x10_busy_before: rbusy=%b exp=%b", rbusy[2], eb); end
    #1 reset = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'd256);
    expb_q.push_back(1'b0);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd[0 +: XLEN] !== e) begin errors++; $display("FAIL ar_x4_after: rd=%h exp=%h", rd[0 +: XLEN], e); end
    e = exp_q.pop_front(); checks++;
    if (rd[XLEN +: XLEN] !== e) begin errors++; $display("FAIL ar_x2_after: rd=%h exp=%h", rd[XLEN +: XLEN], e); end
    eb = expb_q.pop_front(); checks++;
    if (rbusy[2] !== eb) begin errors++; $display("FAIL ar_x10_busy_after: rbusy=%b exp=%b", rbusy[2], eb); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_x0_f0();
    test_write_conflict();
    test_busy();
    test_issue_write();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
